// File: rtl/uart_tx_top.sv
// UART transmit engine: pops bytes from a first-word-fall-through TX FIFO
// and serialises start, 5-8 data bits LSB first, optional parity and
// 1/1.5/2 stop bits, timed by a 16x baud_pulse strobe.
module uart_tx_top #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       stb,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic       pen,
  input  logic [1:0] wls,
  input  logic       set_break,
  input  logic       tx_fifo_empty,
  input  logic [7:0] din,
  output logic       pop,
  output logic       tx,
  output logic       sreg_empty
);

  // Longest state is two stop bits, so the tick counter must hold 2*T-1.
  localparam int TW = $clog2(2 * TICKS_PER_BIT);
  localparam logic [TW-1:0] L_BIT    = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] L_STOP15 = TW'(TICKS_PER_BIT * 3 / 2 - 1);
  localparam logic [TW-1:0] L_STOP2  = TW'(2 * TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tick, w_tick_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_tx, w_tx_nxt;
  logic [1:0]      r_wls;
  logic            r_pen, r_stb, r_par;
  logic            w_pop, w_done;
  logic [TW-1:0]   w_limit;
  logic [7:0]      w_mask;
  logic            w_xor, w_par;

  // Parity is resolved from the live LCR at pop time; only the bits that
  // will actually be sent contribute.
  always_comb begin
    w_mask = 8'hFF;
    case (wls)
      2'b00:   w_mask = 8'h1F;
      2'b01:   w_mask = 8'h3F;
      2'b10:   w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
    w_xor = ^(din & w_mask);
    w_par = sticky_parity ? ~eps : (eps ? w_xor : ~w_xor);
  end

  // Per-state tick limit (minus one) and end-of-state strobe.
  always_comb begin
    w_limit = L_BIT;
    if (r_state == S_STOP && r_stb)
      w_limit = (r_wls == 2'b00) ? L_STOP15 : L_STOP2;
    w_done = baud_pulse && (r_tick == w_limit);
  end

  // Next-state, counters, shifter and next line value.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    if (r_state != S_IDLE && baud_pulse)
      w_tick_nxt = w_done ? '0 : r_tick + TW'(1);
    case (r_state)
      S_IDLE: begin
        if (!tx_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_shift_nxt = din;
        end
      end
      S_START:  if (w_done) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_done) begin
          w_shift_nxt = r_shift >> 1;
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == {1'b0, r_wls} + 3'd4)
            w_state_nxt = r_pen ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (w_done) w_state_nxt = S_STOP;
      S_STOP:   if (w_done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // Line value is registered alongside the state it belongs to.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = r_par;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // State, counters and registered line value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Frame-format snapshot so LCR writes mid-frame do not disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wls <= 2'b00;
      r_pen <= 1'b0;
      r_stb <= 1'b0;
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_wls <= wls;
      r_pen <= pen;
      r_stb <= stb;
      r_par <= w_par;
    end
  end

  // pop is gated by reset so a non-empty FIFO is never popped while held.
  assign pop        = w_pop & rst;
  assign tx         = r_tx & ~set_break;
  assign sreg_empty = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_top.sv
// Self-checking bench for uart_tx_top: directed frames plus random frames
// compared cycle by cycle against a symbol-list model of the serial frame.
module tb_uart_tx_top;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst, baud_pulse, stb, sticky_parity, eps, pen, set_break;
  logic       tx_fifo_empty;
  logic [1:0] wls;
  logic [7:0] din;
  logic       pop, tx, sreg_empty;

  int checks = 0;
  int errors = 0;

  // Expected frame: list of (line value, duration in baud pulses).
  bit vals[$];
  int durs[$];
  int total;

  uart_tx_top #(.TICKS_PER_BIT(T)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .stb(stb),
    .sticky_parity(sticky_parity), .eps(eps), .pen(pen), .wls(wls),
    .set_break(set_break), .tx_fifo_empty(tx_fifo_empty), .din(din),
    .pop(pop), .tx(tx), .sreg_empty(sreg_empty)
  );

  always #5 clk = ~clk;

  // Random 16x strobe, changed away from the active edge.
  initial begin
    baud_pulse = 1'b0;
    forever begin
      @(negedge clk);
      baud_pulse = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void build(input logic [7:0] d, input int w, input bit pe,
                                input bit ep, input bit sk, input bit sb);
    int n, ones;
    bit b, par;
    vals.delete(); durs.delete();
    n = w + 5; ones = 0;
    vals.push_back(1'b0); durs.push_back(T);
    for (int i = 0; i < n; i++) begin
      b = d[i];
      ones += int'(b);
      vals.push_back(b); durs.push_back(T);
    end
    if (pe) begin
      if (sk) par = !ep;
      else    par = ep ? (ones % 2 == 1) : (ones % 2 == 0);
      vals.push_back(par); durs.push_back(T);
    end
    vals.push_back(1'b1);
    durs.push_back(!sb ? T : (w == 0 ? T * 3 / 2 : 2 * T));
    total = 0;
    foreach (durs[i]) total += durs[i];
  endfunction

  function automatic bit exp_at(input int p);
    int acc = 0;
    foreach (durs[i]) begin
      acc += durs[i];
      if (p < acc) return vals[i];
    end
    return 1'b1;
  endfunction

  // Send one frame and follow it pulse by pulse. nxt keeps the FIFO
  // non-empty with nd; brk_lo/brk_hi bound a break window; rst_at aborts.
  task automatic run_frame(input string nm, input logic [7:0] d, input int w,
                           input bit pe, input bit ep, input bit sk, input bit sb,
                           input bit nxt, input logic [7:0] nd,
                           input int brk_lo, input int brk_hi, input int rst_at);
    int p, cyc;
    logic brk;
    build(d, w, pe, ep, sk, sb);
    @(negedge clk);
    din = d; wls = 2'(w); pen = pe; eps = ep; sticky_parity = sk; stb = sb;
    tx_fifo_empty = 1'b0;
    #1 chk({nm, ":pop"}, pop, 1'b1);
    chk({nm, ":idle_temt"}, sreg_empty, 1'b1);
    @(posedge clk);
    #1 chk({nm, ":start"}, tx, 1'b0);
    chk({nm, ":temt_fall"}, sreg_empty, 1'b0);
    chk({nm, ":pop_once"}, pop, 1'b0);
    @(negedge clk);
    // Frame is latched: scramble the LCR and line up the FIFO head.
    tx_fifo_empty = !nxt; din = nxt ? nd : 8'($urandom);
    wls = 2'($urandom); pen = 1'($urandom); eps = 1'($urandom);
    sticky_parity = 1'($urandom); stb = 1'($urandom);
    p = 0; cyc = 0;
    while (p < total) begin
      @(posedge clk);
      if (baud_pulse) p++;
      cyc++;
      #1;
      if (p < total) begin
        chk($sformatf("%s:tx@%0d", nm, p), tx, exp_at(p) & ~set_break);
        chk($sformatf("%s:temt@%0d", nm, p), sreg_empty, 1'b0);
        chk($sformatf("%s:nopop@%0d", nm, p), pop, 1'b0);
      end else begin
        chk({nm, ":end_tx"}, tx, 1'b1);
        chk({nm, ":end_temt"}, sreg_empty, 1'b1);
        chk({nm, ":end_pop"}, pop, nxt);
      end
      brk = (p >= brk_lo) && (p < brk_hi) && (p < total);
      if (brk !== set_break) begin
        set_break = brk;
        #1 chk($sformatf("%s:brk@%0d", nm, p), tx,
               (p < total ? exp_at(p) : 1'b1) & ~brk);
      end
      if (p == rst_at) begin
        #1 rst = 1'b0;
        #1 chk({nm, ":rst_tx"}, tx, 1'b1);
        chk({nm, ":rst_pop"}, pop, 1'b0);
        chk({nm, ":rst_temt"}, sreg_empty, 1'b1);
        return;
      end
      if (cyc > 5000) begin
        chk({nm, ":timeout"}, 1'b0, 1'b1);
        return;
      end
    end
  endtask

  task automatic idle_check(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 chk($sformatf("%s:pop%0d", nm, i), pop, 1'b0);
      chk($sformatf("%s:tx%0d", nm, i), tx, 1'b1);
      chk($sformatf("%s:temt%0d", nm, i), sreg_empty, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b0; stb = 1'b0; sticky_parity = 1'b0; eps = 1'b0; pen = 1'b0;
    wls = 2'b11; set_break = 1'b0; tx_fifo_empty = 1'b0; din = 8'h55;
    #12;
    chk("reset_tx", tx, 1'b1);
    chk("reset_pop", pop, 1'b0);
    chk("reset_temt", sreg_empty, 1'b1);
    tx_fifo_empty = 1'b1;
    @(negedge clk) rst = 1'b1;
    idle_check("post_reset", 4);

    run_frame("8O_45", 8'h45, 3, 1, 0, 0, 0, 0, 8'h00, -1, -1, -1);
    run_frame("5E15_DF", 8'hDF, 0, 1, 1, 0, 1, 0, 8'h00, -1, -1, -1);
    run_frame("stk_e1", 8'h00, 3, 1, 1, 1, 0, 0, 8'h00, -1, -1, -1);
    run_frame("stk_e0", 8'h00, 3, 1, 0, 1, 0, 0, 8'h00, -1, -1, -1);
    run_frame("8N1_00", 8'h00, 3, 0, 0, 1, 0, 0, 8'h00, -1, -1, -1);
    run_frame("b2b_A5", 8'hA5, 3, 0, 0, 0, 0, 1, 8'h3C, -1, -1, -1);
    run_frame("b2b_3C", 8'h3C, 3, 0, 0, 0, 0, 0, 8'h00, -1, -1, -1);
    idle_check("b2b_after", 6);
    run_frame("brk_FF", 8'hFF, 3, 0, 0, 0, 0, 0, 8'h00, 20, 60, -1);
    run_frame("rst_3A", 8'h3A, 3, 0, 0, 0, 0, 0, 8'h00, -1, -1, 70);
    tx_fifo_empty = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    idle_check("rst_after", 20);

    for (int k = 0; k < 8; k++) begin
      run_frame($sformatf("rnd%0d", k), 8'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                0, 8'h00, -1, -1, -1);
    end
    idle_check("final", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait is ever left without a bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
